// File: rtl/text_line_engine.sv
// Text-mode line engine: executes cursor/line/scroll edits on a row-wide text RAM.
// Rows are read with a 2-cycle latency and written back as whole lines.
module text_line_engine #(
  parameter int unsigned       COLS   = 80,
  parameter int unsigned       ROWS   = 30,
  parameter int unsigned       CHAR_W = 32,
  parameter int unsigned       ADDR_W = 8,
  parameter logic [CHAR_W-1:0] BLANK  = CHAR_W'(32'h0007fc20)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [ADDR_W-1:0]      cmd_row,
  input  logic [ADDR_W-1:0]      cmd_col,
  input  logic [ADDR_W-1:0]      cmd_n,
  input  logic [ADDR_W-1:0]      cmd_top,
  input  logic [ADDR_W-1:0]      cmd_bottom,
  input  logic [CHAR_W-1:0]      cmd_char,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic                   ram_wren,
  output logic [COLS*CHAR_W-1:0] ram_wdata,
  input  logic [COLS*CHAR_W-1:0] ram_rdata,
  output logic                   busy
);

  localparam int unsigned W1 = ADDR_W + 1;
  localparam int unsigned LW = COLS * CHAR_W;
  localparam logic [LW-1:0] BLANK_LINE = {COLS{BLANK}};

  localparam logic [2:0] OP_PUTC        = 3'd0;
  localparam logic [2:0] OP_ERASE_ROWS  = 3'd1;
  localparam logic [2:0] OP_SCROLL_UP   = 3'd2;
  localparam logic [2:0] OP_SCROLL_DOWN = 3'd3;
  localparam logic [2:0] OP_ERASE_COLS  = 3'd4;
  localparam logic [2:0] OP_INS_CHARS   = 3'd5;
  localparam logic [2:0] OP_DEL_CHARS   = 3'd6;

  typedef enum logic [2:0] {
    IDLE, LINE_RD, LINE_WAIT, LINE_WR, MOVE_RD, MOVE_WAIT, MOVE_WR, FILL_WR
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_op;
  logic [ADDR_W-1:0] r_row, r_col;
  logic [CHAR_W-1:0] r_char;
  logic [W1-1:0]     r_n, r_top, r_bot;
  logic [W1-1:0]     r_cnt, r_move_end, r_fill_lo, r_fill_hi;
  logic [W1-1:0]     w_cnt_nxt, w_move_end_nxt, w_fill_lo_nxt, w_fill_hi_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              w_wren_nxt;
  logic [LW-1:0]     w_wdata_nxt, w_line_mod;

  logic              w_accept, w_row_bad, w_rows_empty, w_cols_empty;
  logic [W1-1:0]     w_in_n, w_in_top, w_in_bot_row, w_in_bot_col, w_in_height;
  logic [ADDR_W-1:0] w_in_col;

  // Incoming command decode, widened by one bit so region arithmetic never wraps
  assign w_accept     = cmd_valid && cmd_ready;
  assign w_in_n       = (cmd_n == '0) ? W1'(1) : W1'(cmd_n);
  assign w_in_top     = W1'(cmd_top);
  assign w_in_bot_row = (W1'(cmd_bottom) > W1'(ROWS - 1)) ? W1'(ROWS - 1) : W1'(cmd_bottom);
  assign w_in_bot_col = (W1'(cmd_bottom) > W1'(COLS - 1)) ? W1'(COLS - 1) : W1'(cmd_bottom);
  assign w_in_col     = (cmd_col > ADDR_W'(COLS - 1)) ? ADDR_W'(COLS - 1) : cmd_col;
  assign w_row_bad    = W1'(cmd_row) >= W1'(ROWS);
  assign w_rows_empty = w_in_top > w_in_bot_row;
  assign w_cols_empty = w_in_top > w_in_bot_col;
  assign w_in_height  = w_in_bot_row - w_in_top + W1'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_move_end_nxt = r_move_end;
    w_fill_lo_nxt  = r_fill_lo;
    w_fill_hi_nxt  = r_fill_hi;
    w_addr_nxt     = ram_addr;
    w_wren_nxt     = 1'b0;
    w_wdata_nxt    = ram_wdata;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          case (cmd_op)
            OP_PUTC, OP_INS_CHARS, OP_DEL_CHARS: begin
              if (!w_row_bad) begin
                w_state_nxt = LINE_RD;
                w_addr_nxt  = cmd_row;
              end
            end
            OP_ERASE_COLS: begin
              if (!w_row_bad && !w_cols_empty) begin
                w_state_nxt = LINE_RD;
                w_addr_nxt  = cmd_row;
              end
            end
            OP_ERASE_ROWS, OP_SCROLL_UP, OP_SCROLL_DOWN: begin
              if (!w_rows_empty) begin
                if (cmd_op == OP_ERASE_ROWS || w_in_n >= w_in_height) begin
                  w_state_nxt   = FILL_WR;
                  w_cnt_nxt     = w_in_top;
                  w_fill_hi_nxt = w_in_bot_row;
                  w_addr_nxt    = cmd_top;
                  w_wren_nxt    = 1'b1;
                  w_wdata_nxt   = BLANK_LINE;
                end else if (cmd_op == OP_SCROLL_UP) begin
                  w_state_nxt    = MOVE_RD;
                  w_cnt_nxt      = w_in_top;
                  w_move_end_nxt = w_in_bot_row - w_in_n;
                  w_fill_lo_nxt  = w_in_bot_row - w_in_n + W1'(1);
                  w_fill_hi_nxt  = w_in_bot_row;
                  w_addr_nxt     = ADDR_W'(w_in_top + w_in_n);
                end else begin
                  w_state_nxt    = MOVE_RD;
                  w_cnt_nxt      = w_in_bot_row;
                  w_move_end_nxt = w_in_top + w_in_n;
                  w_fill_lo_nxt  = w_in_top;
                  w_fill_hi_nxt  = w_in_top + w_in_n - W1'(1);
                  w_addr_nxt     = ADDR_W'(w_in_bot_row - w_in_n);
                end
              end
            end
            default: ;
          endcase
        end
      end
      LINE_RD:   w_state_nxt = LINE_WAIT;
      LINE_WAIT: begin
        w_state_nxt = LINE_WR;
        w_addr_nxt  = r_row;
        w_wren_nxt  = 1'b1;
        w_wdata_nxt = w_line_mod;
      end
      LINE_WR:   w_state_nxt = IDLE;
      MOVE_RD:   w_state_nxt = MOVE_WAIT;
      MOVE_WAIT: begin
        w_state_nxt = MOVE_WR;
        w_addr_nxt  = ADDR_W'(r_cnt);
        w_wren_nxt  = 1'b1;
        w_wdata_nxt = ram_rdata;
      end
      MOVE_WR: begin
        if (r_cnt == r_move_end) begin
          w_state_nxt = FILL_WR;
          w_cnt_nxt   = r_fill_lo;
          w_addr_nxt  = ADDR_W'(r_fill_lo);
          w_wren_nxt  = 1'b1;
          w_wdata_nxt = BLANK_LINE;
        end else if (r_op == OP_SCROLL_UP) begin
          w_state_nxt = MOVE_RD;
          w_cnt_nxt   = r_cnt + W1'(1);
          w_addr_nxt  = ADDR_W'(r_cnt + W1'(1) + r_n);
        end else begin
          w_state_nxt = MOVE_RD;
          w_cnt_nxt   = r_cnt - W1'(1);
          w_addr_nxt  = ADDR_W'(r_cnt - W1'(1) - r_n);
        end
      end
      FILL_WR: begin
        if (r_cnt == r_fill_hi) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt   = r_cnt + W1'(1);
          w_addr_nxt  = ADDR_W'(r_cnt + W1'(1));
          w_wren_nxt  = 1'b1;
          w_wdata_nxt = BLANK_LINE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Single-line edit applied to the row just read back
  always_comb begin
    w_line_mod = ram_rdata;
    for (int i = 0; i < int'(COLS); i++) begin
      case (r_op)
        OP_PUTC:
          if (i == int'(r_col)) w_line_mod[i*CHAR_W +: CHAR_W] = r_char;
        OP_ERASE_COLS:
          if (i >= int'(r_top) && i <= int'(r_bot)) w_line_mod[i*CHAR_W +: CHAR_W] = BLANK;
        OP_INS_CHARS:
          if (i >= int'(r_col)) begin
            if (i < int'(r_col) + int'(r_n)) w_line_mod[i*CHAR_W +: CHAR_W] = BLANK;
            else w_line_mod[i*CHAR_W +: CHAR_W] = ram_rdata[(i - int'(r_n))*CHAR_W +: CHAR_W];
          end
        OP_DEL_CHARS:
          if (i >= int'(r_col)) begin
            if (i + int'(r_n) < int'(COLS))
              w_line_mod[i*CHAR_W +: CHAR_W] = ram_rdata[(i + int'(r_n))*CHAR_W +: CHAR_W];
            else w_line_mod[i*CHAR_W +: CHAR_W] = BLANK;
          end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op   <= '0;
      r_row  <= '0;
      r_col  <= '0;
      r_char <= '0;
      r_n    <= '0;
      r_top  <= '0;
      r_bot  <= '0;
    end else if (w_accept) begin
      r_op   <= cmd_op;
      r_row  <= cmd_row;
      r_col  <= w_in_col;
      r_char <= cmd_char;
      r_n    <= w_in_n;
      r_top  <= w_in_top;
      r_bot  <= (cmd_op == OP_ERASE_COLS) ? w_in_bot_col : w_in_bot_row;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      ram_addr   <= '0;
      ram_wren   <= 1'b0;
      ram_wdata  <= '0;
      r_cnt      <= '0;
      r_move_end <= '0;
      r_fill_lo  <= '0;
      r_fill_hi  <= '0;
    end else begin
      cmd_ready  <= (w_state_nxt == IDLE);
      busy       <= (w_state_nxt != IDLE);
      ram_addr   <= w_addr_nxt;
      ram_wren   <= w_wren_nxt;
      ram_wdata  <= w_wdata_nxt;
      r_cnt      <= w_cnt_nxt;
      r_move_end <= w_move_end_nxt;
      r_fill_lo  <= w_fill_lo_nxt;
      r_fill_hi  <= w_fill_hi_nxt;
    end
  end

endmodule

// File: tb/tb_text_line_engine.sv
// Self-checking bench for text_line_engine: directed corner cases plus random commands
// compared against a cell-array model of the text RAM.
module tb_text_line_engine;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int CHAR_W = 32;
  localparam int ADDR_W = 8;
  localparam int LW     = COLS * CHAR_W;
  localparam logic [CHAR_W-1:0] BLANK = 32'h0007fc20;
  localparam int LIMIT  = 400;

  logic              clk, rst, cmd_valid, cmd_ready, ram_wren, busy;
  logic [2:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_row, cmd_col, cmd_n, cmd_top, cmd_bottom, ram_addr;
  logic [CHAR_W-1:0] cmd_char;
  logic [LW-1:0]     ram_wdata, ram_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  text_line_engine #(
    .COLS(COLS), .ROWS(ROWS), .CHAR_W(CHAR_W), .ADDR_W(ADDR_W), .BLANK(BLANK)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_n(cmd_n),
    .cmd_top(cmd_top), .cmd_bottom(cmd_bottom), .cmd_char(cmd_char),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Text RAM: registered read, read-before-write, plus a bench-side preload port
  logic [LW-1:0]     mem [ROWS];
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [LW-1:0]     ld_data;

  always @(posedge clk) begin
    if (int'(ram_addr) < ROWS) ram_rdata <= mem[int'(ram_addr)];
    else                       ram_rdata <= '0;
    if (ram_wren && int'(ram_addr) < ROWS) mem[int'(ram_addr)] <= ram_wdata;
    if (ld_en) mem[int'(ld_addr)] <= ld_data;
  end

  logic [CHAR_W-1:0] mdl [ROWS][COLS];
  int exp_addr[$];
  int exp_cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_row(input int r, input logic [LW-1:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = ADDR_W'(r); ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
    for (int i = 0; i < COLS; i++) mdl[r][i] = d[i*CHAR_W +: CHAR_W];
  endtask

  task automatic load_random();
    logic [LW-1:0] d;
    for (int r = 0; r < ROWS; r++) begin
      for (int i = 0; i < COLS; i++) d[i*CHAR_W +: CHAR_W] = $urandom();
      load_row(r, d);
    end
  endtask

  // Expected RAM contents and write sequence, derived from the command rules
  task automatic model_apply(input int op, input int row, input int col, input int n,
                             input int top, input int bot, input logic [CHAR_W-1:0] ch);
    logic [CHAR_W-1:0] old [ROWS][COLS];
    int nn, c, b, h, mv, src;
    bit line_op, bad;
    old = mdl;
    exp_addr.delete();
    nn = (n == 0) ? 1 : n;
    c  = (col > COLS - 1) ? COLS - 1 : col;
    line_op = (op == 0 || op == 4 || op == 5 || op == 6);
    if (line_op) b = (bot > COLS - 1) ? COLS - 1 : bot;
    else         b = (bot > ROWS - 1) ? ROWS - 1 : bot;
    bad = (op == 7) || (line_op && row >= ROWS) || (op == 4 && top > b) || (!line_op && top > b);
    if (bad) begin
      exp_cyc = 1;
      return;
    end
    if (line_op) begin
      exp_cyc = 4;
      exp_addr.push_back(row);
      for (int i = 0; i < COLS; i++) begin
        case (op)
          0: if (i == c) mdl[row][i] = ch;
          4: if (i >= top && i <= b) mdl[row][i] = BLANK;
          5: if (i >= c) mdl[row][i] = (i < c + nn) ? BLANK : old[row][i-nn];
          6: if (i >= c) mdl[row][i] = (i + nn < COLS) ? old[row][i+nn] : BLANK;
          default: ;
        endcase
      end
    end else begin
      h  = b - top + 1;
      mv = (op == 1 || nn >= h) ? 0 : h - nn;
      for (int r = top; r <= b; r++) begin
        src = (op == 2) ? r + nn : r - nn;
        for (int i = 0; i < COLS; i++) begin
          if (op == 1 || src < top || src > b) mdl[r][i] = BLANK;
          else                                  mdl[r][i] = old[src][i];
        end
      end
      if (mv == 0) begin
        for (int r = top; r <= b; r++) exp_addr.push_back(r);
      end else if (op == 2) begin
        for (int r = top; r <= b; r++) exp_addr.push_back(r);
      end else begin
        for (int r = b; r >= top + nn; r--) exp_addr.push_back(r);
        for (int r = top; r < top + nn; r++) exp_addr.push_back(r);
      end
      exp_cyc = 1 + 3 * mv + (h - mv);
    end
  endtask

  task automatic compare_mem(input string tag);
    int bad;
    bad = 0;
    for (int r = 0; r < ROWS; r++)
      for (int i = 0; i < COLS; i++)
        if (mem[r][i*CHAR_W +: CHAR_W] !== mdl[r][i]) bad++;
    check({tag, "_mem"}, 64'(bad), 64'd0);
  endtask

  // Offer one command; returns on the negedge of the first cycle after acceptance
  task automatic send(input int op, input int row, input int col, input int n,
                      input int top, input int bot, input logic [CHAR_W-1:0] ch);
    int w;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < LIMIT) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) check("ready_wait", 64'd0, 64'd1);
    cmd_op = 3'(op); cmd_row = ADDR_W'(row); cmd_col = ADDR_W'(col); cmd_n = ADDR_W'(n);
    cmd_top = ADDR_W'(top); cmd_bottom = ADDR_W'(bot); cmd_char = ch;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input string tag, input int op, input int row, input int col, input int n,
                         input int top, input int bot, input logic [CHAR_W-1:0] ch);
    int k, wr, aerr, berr;
    bit done;
    model_apply(op, row, col, n, top, bot, ch);
    send(op, row, col, n, top, bot, ch);
    k = 1; wr = 0; aerr = 0; berr = 0; done = 1'b0;
    while (!done && k <= LIMIT) begin
      if (busy === cmd_ready) berr++;
      if (ram_wren === 1'b1) begin
        if (!(wr < exp_addr.size() && int'(ram_addr) == exp_addr[wr])) aerr++;
        wr++;
      end
      if (cmd_ready === 1'b1) done = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    if (!done) check({tag, "_timeout"}, 64'd0, 64'd1);
    check({tag, "_cycles"}, 64'(k), 64'(exp_cyc));
    check({tag, "_writes"}, 64'(wr), 64'(exp_addr.size()));
    check({tag, "_wraddr"}, 64'(aerr), 64'd0);
    check({tag, "_busy"}, 64'(berr), 64'd0);
    compare_mem(tag);
  endtask

  initial begin
    logic [LW-1:0] d;
    logic [CHAR_W-1:0] old1 [COLS];
    int op, row, col, n, top, bot, cc;

    rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_row = '0; cmd_col = '0; cmd_n = '0;
    cmd_top = '0; cmd_bottom = '0; cmd_char = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_wren",  64'(ram_wren), 64'd0);
    check("rst_addr",  64'(ram_addr), 64'd0);
    check("rst_wdata", 64'(ram_wdata == '0), 64'd1);
    rst = 1'b1;

    load_random();

    run_cmd("putc79", 0, 3, 79, 0, 0, 0, 32'h41);
    check("putc79_cell", 64'(mem[3][79*CHAR_W +: CHAR_W]), 64'h41);

    run_cmd("scroll_up_all", 2, 0, 0, 1, 0, 29, 0);
    run_cmd("scroll_dn_big", 3, 0, 0, 7, 5, 9, 0);
    run_cmd("erase_rows_inv", 1, 0, 0, 0, 10, 4, 0);

    for (int i = 0; i < COLS; i++) d[i*CHAR_W +: CHAR_W] = CHAR_W'(i);
    load_row(2, d);
    run_cmd("ins78", 5, 2, 78, 0, 0, 0, 0);
    check("ins78_c78", 64'(mem[2][78*CHAR_W +: CHAR_W]), 64'(BLANK));
    check("ins78_c79", 64'(mem[2][79*CHAR_W +: CHAR_W]), 64'd78);

    run_cmd("op7", 7, 1, 1, 1, 1, 1, 0);
    run_cmd("row_oob", 0, ROWS, 5, 0, 0, 0, 32'h99);

    // Reset during the second move of a scroll: only the first move lands
    load_random();
    for (int i = 0; i < COLS; i++) old1[i] = mdl[1][i];
    send(2, 0, 0, 1, 0, 29, 0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_wren",  64'(ram_wren), 64'd0);
    check("mid_rst_ready", 64'(cmd_ready), 64'd1);
    check("mid_rst_busy",  64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < COLS; i++) mdl[0][i] = old1[i];
    compare_mem("mid_rst");
    run_cmd("rst_putc", 0, 7, 12, 0, 0, 0, 32'h5a5a);

    for (int t = 0; t < 40; t++) begin
      op  = $urandom_range(0, 7);
      row = ($urandom_range(0, 15) == 0) ? $urandom_range(ROWS, 255) : $urandom_range(0, ROWS - 1);
      col = ($urandom_range(0, 7) == 0) ? $urandom_range(COLS, 255) : $urandom_range(0, COLS - 1);
      n   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 6);
      if (op == 4) begin
        top = $urandom_range(0, 85);
        bot = $urandom_range(0, 95);
      end else begin
        top = $urandom_range(0, 31);
        bot = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 40);
      end
      if (op == 6) begin
        cc = (col > COLS - 1) ? COLS - 1 : col;
        if (n + cc > COLS) n = COLS - cc;
      end
      run_cmd("rand", op, row, col, n, top, bot, $urandom());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
